// File: rtl/osd_stm_mor1kx_mc.sv
// Multi-core mor1kx software-trace extractor: per-core l.nop marker capture into
// FIFOs with drop accounting, merged round-robin into one valid/ready event stream.
module osd_stm_mor1kx_mc #(
    parameter int          NCORES     = 2,
    parameter int          XLEN       = 32,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [4:0]  VALUE_REG  = 5'd3,
    parameter logic [15:0] MARKER_HI  = 16'h1500,
    localparam int         CW         = (NCORES > 1) ? $clog2(NCORES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCORES-1:0]      trace_valid,
    input  logic [NCORES*32-1:0]   trace_insn,
    input  logic [NCORES-1:0]      trace_wben,
    input  logic [NCORES*5-1:0]    trace_wbreg,
    input  logic [NCORES*XLEN-1:0] trace_wbdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            out_id,
    output logic [XLEN-1:0]        out_value,
    output logic [CW-1:0]          out_core
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW = 16 + XLEN;

    logic [EW-1:0]     head [NCORES];
    logic [NCORES-1:0] nonempty;
    logic [NCORES-1:0] pop;
    logic [CW-1:0]     last_grant;
    logic [CW-1:0]     grant;
    logic              grant_valid;
    logic              load;

    for (genvar i = 0; i < NCORES; i++) begin : g_core
        logic [XLEN-1:0] shadow;
        logic [EW-1:0]   mem [FIFO_DEPTH];
        logic [PW-1:0]   wr_ptr;
        logic [PW-1:0]   rd_ptr;
        logic [PW:0]     count;
        logic [15:0]     drop_cnt;
        logic [15:0]     drop_next;
        logic [31:0]     insn;
        logic            marker;
        logic            full;
        logic            push_ovf;
        logic            push_mk;
        logic            push;
        logic [EW-1:0]   push_data;

        assign insn = trace_insn[32*i +: 32];

        // NOTE: every signal gets a value on every path so no latches are inferred.
        always_comb begin
            marker    = trace_valid[i] && (insn[31:16] == MARKER_HI) && (insn[15:0] != 16'h0000);
            // A pop in the same cycle does not free a slot for this cycle's write.
            full      = (count == (PW+1)'(FIFO_DEPTH));
            push_ovf  = (drop_cnt != 16'h0000) && !full;
            push_mk   = !push_ovf && marker && !full;
            push      = push_ovf || push_mk;
            push_data = push_ovf ? {16'h0000, XLEN'(drop_cnt)} : {insn[15:0], shadow};
            drop_next = drop_cnt;
            if (push_ovf)
                drop_next = marker ? 16'd1 : 16'd0;
            else if (marker && full && (drop_cnt != 16'hFFFF))
                drop_next = drop_cnt + 16'd1;
        end

        // NOTE: state uses non-blocking assignments so all registers update together.
        always_ff @(posedge clk) begin
            if (rst) begin
                shadow   <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                drop_cnt <= '0;
            end else begin
                if (trace_wben[i] && (trace_wbreg[5*i +: 5] == VALUE_REG))
                    shadow <= trace_wbdata[XLEN*i +: XLEN];
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop[i])
                    rd_ptr <= rd_ptr + PW'(1);
                count    <= count + (PW+1)'(push) - (PW+1)'(pop[i]);
                drop_cnt <= drop_next;
            end
        end

        // NOTE: the storage array has no reset; occupancy lives in count/pointers.
        always_ff @(posedge clk) begin
            if (push)
                mem[wr_ptr] <= push_data;
        end

        assign head[i]     = mem[rd_ptr];
        assign nonempty[i] = (count != '0);
    end

    // Round-robin: search starts one past the last granted core.
    always_comb begin
        int idx;
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = 0; k < NCORES; k++) begin
            idx = (int'(last_grant) + 1 + k) % NCORES;
            if (!grant_valid && nonempty[idx[CW-1:0]]) begin
                grant_valid = 1'b1;
                grant       = idx[CW-1:0];
            end
        end
    end

    assign load = !out_valid || out_ready;

    always_comb begin
        pop = '0;
        if (load && grant_valid)
            pop[grant] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_id     <= '0;
            out_value  <= '0;
            out_core   <= '0;
            last_grant <= CW'(NCORES - 1);
        end else if (load) begin
            out_valid <= grant_valid;
            if (grant_valid) begin
                out_id     <= head[grant][EW-1:XLEN];
                out_value  <= head[grant][XLEN-1:0];
                out_core   <= grant;
                last_grant <= grant;
            end
        end
    end

endmodule

// File: tb/tb_osd_stm_mor1kx_mc.sv
// Directed bench for osd_stm_mor1kx_mc (NCORES=2, FIFO_DEPTH=4): latency, shadow
// timing, overflow records, round-robin order, back-pressure stability and reset.
module tb_osd_stm_mor1kx_mc;

    localparam int NC = 2;
    localparam int XL = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [NC-1:0]   trace_valid;
    logic [NC*32-1:0] trace_insn;
    logic [NC-1:0]   trace_wben;
    logic [NC*5-1:0] trace_wbreg;
    logic [NC*XL-1:0] trace_wbdata;
    logic            out_valid;
    logic            out_ready;
    logic [15:0]     out_id;
    logic [XL-1:0]   out_value;
    logic [0:0]      out_core;

    int vectors     = 0;
    int miscompares = 0;

    osd_stm_mor1kx_mc #(
        .NCORES(NC), .XLEN(XL), .FIFO_DEPTH(4), .VALUE_REG(5'd3), .MARKER_HI(16'h1500)
    ) dut (
        .clk(clk), .rst(rst),
        .trace_valid(trace_valid), .trace_insn(trace_insn),
        .trace_wben(trace_wben), .trace_wbreg(trace_wbreg), .trace_wbdata(trace_wbdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_id(out_id), .out_value(out_value), .out_core(out_core)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_ev(input string tag, input logic [15:0] id, input logic [31:0] val,
                             input logic [0:0] core);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_id"},    64'(out_id),    64'(id));
        check({tag, "_value"}, 64'(out_value), 64'(val));
        check({tag, "_core"},  64'(out_core),  64'(core));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        trace_valid  = '0;
        trace_insn   = '0;
        trace_wben   = '0;
        trace_wbreg  = '0;
        trace_wbdata = '0;
    endtask

    task automatic drive_marker(input int c, input logic [15:0] id);
        trace_valid[c]        = 1'b1;
        trace_insn[32*c +: 32] = {16'h1500, id};
    endtask

    task automatic write_reg(input int c, input logic [4:0] r, input logic [31:0] d);
        trace_wben[c]           = 1'b1;
        trace_wbreg[5*c +: 5]   = r;
        trace_wbdata[XL*c +: XL] = d;
    endtask

    logic [15:0] exp_q [2][$];
    logic [31:0] exp_val [2];
    logic        pv, pr;
    logic [15:0] pid;
    logic [31:0] pval;
    logic [0:0]  pcore;
    int          n0, n1;
    logic [15:0] ovf_ids [5];

    initial begin
        clear_in();
        out_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_id",    64'(out_id),    64'd0);
        check("rst_value", 64'(out_value), 64'd0);
        check("rst_core",  64'(out_core),  64'd0);

        // Basic event: r3 write, then marker 0x0042, visible two cycles later.
        out_ready = 1'b1;
        write_reg(0, 5'd3, 32'hDEADBEEF);
        step();
        clear_in();
        drive_marker(0, 16'h0042);
        step();
        clear_in();
        check("lat_not_yet", 64'(out_valid), 64'd0);
        step();
        expect_ev("basic", 16'h0042, 32'hDEADBEEF, 1'b0);
        step();
        check("basic_drained", 64'(out_valid), 64'd0);

        // l.nop 0 and a wrong high half produce nothing.
        trace_valid = 2'b11;
        trace_insn  = {32'h15010042, 32'h15000000};
        step();
        clear_in();
        step();
        step();
        check("nop0_no_event", 64'(out_valid), 64'd0);

        // Same-cycle write is not seen by the marker; the next marker sees it.
        write_reg(0, 5'd3, 32'h1);
        step();
        clear_in();
        write_reg(0, 5'd3, 32'h2);
        drive_marker(0, 16'h0007);
        step();
        clear_in();
        step();
        expect_ev("same_cyc", 16'h0007, 32'h1, 1'b0);
        drive_marker(0, 16'h0008);
        step();
        clear_in();
        step();
        expect_ev("after_wr", 16'h0008, 32'h2, 1'b0);
        step();
        check("after_wr_drained", 64'(out_valid), 64'd0);

        // Overflow: output register stalled on 0x0F, 4 stored, 3 dropped.
        out_ready = 1'b0;
        drive_marker(0, 16'h000F);
        step();
        clear_in();
        step();
        for (int k = 0; k < 7; k++) begin
            clear_in();
            drive_marker(0, 16'h0010 + 16'(k));
            step();
        end
        clear_in();
        step();
        expect_ev("ovf_stall", 16'h000F, 32'h2, 1'b0);
        out_ready = 1'b1;
        ovf_ids = '{16'h0010, 16'h0011, 16'h0012, 16'h0013, 16'h0000};
        for (int k = 0; k < 5; k++) begin
            step();
            expect_ev($sformatf("ovf_seq%0d", k), ovf_ids[k], (k == 4) ? 32'd3 : 32'h2, 1'b0);
        end
        step();
        check("ovf_drained", 64'(out_valid), 64'd0);
        drive_marker(0, 16'h0020);
        step();
        clear_in();
        step();
        expect_ev("ovf_next", 16'h0020, 32'h2, 1'b0);

        // Round-robin after reset: priority starts at core 0.
        rst = 1'b1;
        out_ready = 1'b0;
        step();
        rst = 1'b0;
        check("rst2_valid", 64'(out_valid), 64'd0);
        check("rst2_id",    64'(out_id),    64'd0);
        write_reg(1, 5'd3, 32'h11111111);
        write_reg(0, 5'd4, 32'h0000FFFF);
        step();
        clear_in();
        for (int k = 0; k < 3; k++) begin
            clear_in();
            drive_marker(0, 16'h00A1 + 16'(k));
            drive_marker(1, 16'h00B1 + 16'(k));
            step();
        end
        clear_in();
        expect_ev("rr0", 16'h00A1, 32'h0, 1'b0);
        out_ready = 1'b1;
        step(); expect_ev("rr1", 16'h00B1, 32'h11111111, 1'b1);
        step(); expect_ev("rr2", 16'h00A2, 32'h0,        1'b0);
        step(); expect_ev("rr3", 16'h00B2, 32'h11111111, 1'b1);
        step(); expect_ev("rr4", 16'h00A3, 32'h0,        1'b0);
        step(); expect_ev("rr5", 16'h00B3, 32'h11111111, 1'b1);
        step();
        check("rr_drained", 64'(out_valid), 64'd0);

        // Back-pressure with a pseudo-random ready pattern and a per-core scoreboard.
        exp_val[0] = 32'h0;
        exp_val[1] = 32'h11111111;
        n0 = 0;
        n1 = 0;
        for (int cyc = 0; cyc < 260; cyc++) begin
            clear_in();
            if (cyc < 160 && (cyc % 8) == 0) begin
                drive_marker(0, 16'h0100 + 16'(n0));
                exp_q[0].push_back(16'h0100 + 16'(n0));
                n0++;
            end
            if (cyc < 160 && (cyc % 8) == 4) begin
                drive_marker(1, 16'h0200 + 16'(n1));
                exp_q[1].push_back(16'h0200 + 16'(n1));
                n1++;
            end
            out_ready = 1'($urandom_range(0, 1));
            pv    = out_valid;
            pr    = out_ready;
            pid   = out_id;
            pval  = out_value;
            pcore = out_core;
            step();
            if (pv && pr) begin
                if (exp_q[pcore].size() == 0)
                    check("bp_extra_event", 64'(exp_q[pcore].size()), 64'd1);
                else begin
                    check("bp_id",  64'(pid),  64'(exp_q[pcore].pop_front()));
                    check("bp_val", 64'(pval), 64'(exp_val[pcore]));
                end
            end else if (pv && !pr) begin
                check("bp_hold_valid", 64'(out_valid), 64'd1);
                check("bp_hold_id",    64'(out_id),    64'(pid));
                check("bp_hold_value", 64'(out_value), 64'(pval));
                check("bp_hold_core",  64'(out_core),  64'(pcore));
            end
        end
        clear_in();
        check("bp_left_core0", 64'(exp_q[0].size()), 64'd0);
        check("bp_left_core1", 64'(exp_q[1].size()), 64'd0);

        // Reset with buffered events and drop_cnt=5 discards everything.
        out_ready = 1'b0;
        step();
        for (int k = 0; k < 10; k++) begin
            clear_in();
            drive_marker(0, 16'h0300 + 16'(k));
            step();
        end
        clear_in();
        expect_ev("prerst", 16'h0300, 32'h0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_id",    64'(out_id),    64'd0);
        check("mid_rst_value", 64'(out_value), 64'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            check($sformatf("post_rst_quiet%0d", k), 64'(out_valid), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
